hamming_uart_tx_fifo: RTL and testbench

Parametrised successor to the single-nibble Hamming/UART transmit path. It accepts 4-bit nibbles over a valid/ready handshake and Hamming(7,4)-encodes each one, optionally extending it to SECDED(8,4). Encoded bytes are buffered in a FIFO and sent back-to-back as 8N1/8N2 UART frames at a programmable bit period. It sits between the user-input sampling logic and the `tx` pin, replacing the edge-triggered one-shot path.

---
 rtl/hamming_uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/hamming_uart_tx_fifo.sv | 109 ++++++++++
 tb/tb_hamming_uart_tx_fifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_uart_pkg.sv
// hamming_uart_pkg: shared state type, frame constant and Hamming(7,4)/SECDED encoder
package hamming_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    // code[6:0] = {d3, d2, d1, p4, d0, p2, p1}; bit 7 is overall parity only in SECDED mode
    function automatic logic [7:0] hamming74_encode(input logic [3:0] d, input logic secded);
        logic [6:0] c;
        c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
        return {secded & (^c), c};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    end

    // storage needs no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hamming_uart_tx_fifo.sv
// hamming_uart_tx_fifo: Hamming-encodes nibbles, queues them and sends back-to-back UART frames
module hamming_uart_tx_fifo
    import hamming_uart_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int SECDED       = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_data,
    output logic                       tx,
    output logic                       tx_busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    uart_state_e               state_q, state_d;
    logic [BW-1:0]             baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic [7:0]                code, rd_data;
    logic                      full, empty, pop, baud_last, stop_last;

    assign code      = hamming74_encode(in_data, SECDED != 0);
    assign in_ready  = !full;
    assign baud_last = baud_q == BW'(CLKS_PER_BIT - 1);
    assign stop_last = state_q == STOP && baud_last && bit_q == 3'(STOP_BITS - 1);
    assign pop       = !empty && (state_q == IDLE || stop_last);
    assign tx        = tx_q;
    assign tx_busy   = state_q != IDLE;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_valid && !full),
        .wr_data (code),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    // next-state logic; a pop overrides everything so the next frame starts with no idle gap
    always_comb begin
        state_d = state_q;
        baud_d  = baud_last ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: baud_d = '0;
            START: if (baud_last) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            DATA: if (baud_last) begin
                bit_d   = bit_q + 1'b1;
                shift_d = shift_q >> 1;
                tx_d    = shift_q[1];
                if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                    state_d = STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            STOP: if (baud_last) begin
                bit_d = bit_q + 1'b1;
                if (bit_q == 3'(STOP_BITS - 1)) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: ;
        endcase
        if (pop) begin
            state_d = START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = rd_data;
            tx_d    = 1'b0;
        end
    end

    // transmitter state, counters and registered line output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_hamming_uart_tx_fifo.sv
// tb_hamming_uart_tx_fifo: table, corner-case and random checks of two configurations against a frame-level model
module tb_hamming_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       iv [2];
    logic [3:0] id [2];
    logic       tx [2];
    logic       busy [2];
    logic       rdy [2];
    logic [2:0] cnt [2];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    // instance 0: 8N1, plain Hamming(7,4); instance 1: 8N2, SECDED
    hamming_uart_tx_fifo #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .SECDED(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(id[0]),
        .tx(tx[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]));

    hamming_uart_tx_fifo #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .SECDED(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(id[1]),
        .tx(tx[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]));

    task automatic chk(input string name, input int i, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst%0d got=%0d want=%0d at %0t", name, i, act, exp, $time);
        end
    endtask

    // reference encoder from the parity equations; instance index doubles as the SECDED flag
    function automatic logic [7:0] ref_enc(input logic [3:0] d, input int sec);
        int p1, p2, p4;
        logic [6:0] c;
        p1 = (int'(d[0]) + int'(d[1]) + int'(d[3])) % 2;
        p2 = (int'(d[0]) + int'(d[2]) + int'(d[3])) % 2;
        p4 = (int'(d[1]) + int'(d[2]) + int'(d[3])) % 2;
        c = {d[3], d[2], d[1], p4[0], d[0], p2[0], p1[0]};
        return {sec != 0 && ($countones(c) % 2) == 1, c};
    endfunction

    // frame-level model: a byte queue plus the position inside the frame on the line
    logic [7:0] mq [2][$];
    logic [7:0] mcur [2];
    int         mpos [2];
    bit         mbusy [2];

    function automatic logic line_bit(input int i, input int pos);
        int k;
        k = pos / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return mcur[i][k-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        logic acc;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mq[i].delete();
                mbusy[i] = 1'b0;
                mpos[i] = 0;
            end else begin
                acc = iv[i] && mq[i].size() < DEPTH;
                if (mbusy[i]) begin
                    mpos[i]++;
                    if (mpos[i] == (10 + i) * CPB) mbusy[i] = 1'b0;
                end
                if (!mbusy[i] && mq[i].size() > 0) begin
                    mcur[i] = mq[i].pop_front();
                    mbusy[i] = 1'b1;
                    mpos[i] = 0;
                end
                if (acc) mq[i].push_back(ref_enc(id[i], i));
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                chk("rst_tx", i, tx[i], 1);
                chk("rst_busy", i, busy[i], 0);
                chk("rst_count", i, cnt[i], 0);
                chk("rst_ready", i, rdy[i], 1);
            end else begin
                chk("tx", i, tx[i], mbusy[i] ? line_bit(i, mpos[i]) : 1'b1);
                chk("busy", i, busy[i], mbusy[i]);
                chk("count", i, cnt[i], mq[i].size());
                chk("ready", i, rdy[i], mq[i].size() < DEPTH);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy[0] || busy[1] || cnt[0] != 0 || cnt[1] != 0) && n < 800) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 0, n < 800, 1);
    endtask

    typedef struct {
        int         inst;
        logic [3:0] nib;
        logic [7:0] code;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int i, n, acc;
        logic r, seen;
        logic [7:0] got;
        vecs[0] = '{0, 4'hB, 8'h55};
        vecs[1] = '{1, 4'h1, 8'h87};
        vecs[2] = '{1, 4'h0, 8'h00};
        vecs[3] = '{1, 4'hB, 8'h55};
        vecs[4] = '{0, 4'h1, 8'h07};
        vecs[5] = '{0, 4'h2, 8'h19};
        vecs[6] = '{0, 4'h3, 8'h1E};
        vecs[7] = '{1, 4'hF, 8'hFF};
        vecs[8] = '{1, 4'h4, 8'hAA};
        vecs[9] = '{0, 4'h8, 8'h4B};
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0;
            id[k] = 4'h0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int v = 0; v < 10; v++) begin
            wait_idle();
            i = vecs[v].inst;
            iv[i] = 1'b1;
            id[i] = vecs[v].nib;
            @(negedge clk);
            iv[i] = 1'b0;
            id[i] = 4'($urandom);
            n = 0;
            while (tx[i] && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("latency", i, n, 1);
            repeat (CPB + CPB / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                if (k != 0) repeat (CPB) @(negedge clk);
                got[k] = tx[i];
            end
            chk("table_code", i, got, vecs[v].code);
        end
        wait_idle();
        iv[0] = 1'b1;
        id[0] = 4'h0;
        acc = 0;
        seen = 1'b0;
        for (int c = 0; c < 300 && acc < 6; c++) begin
            r = rdy[0];
            @(negedge clk);
            if (r) begin
                acc++;
                id[0] = 4'(acc);
            end
            if (cnt[0] == 3'd4 && !rdy[0]) seen = 1'b1;
        end
        iv[0] = 1'b0;
        chk("fill_accepts", 0, acc, 6);
        chk("fill_full_seen", 0, seen, 1);
        wait_idle();
        iv[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            id[0] = 4'(k + 8);
            @(negedge clk);
        end
        iv[0] = 1'b0;
        chk("pre_rst_count", 0, cnt[0], 3);
        repeat (10) @(negedge clk);
        chk("pre_rst_tx_data_low", 0, tx[0], 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 0, tx[0], 1);
        chk("async_rst_busy", 0, busy[0], 0);
        chk("async_rst_count", 0, cnt[0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_rst_tx", 0, tx[0], 1);
        chk("post_rst_busy", 0, busy[0], 0);
        chk("post_rst_count", 0, cnt[0], 0);
        iv[0] = 1'b1;
        id[0] = 4'h5;
        @(negedge clk);
        id[0] = 4'h6;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (CPB * 10 - 1) @(negedge clk);
        chk("coinc_pre_count", 0, cnt[0], 1);
        chk("coinc_pre_busy", 0, busy[0], 1);
        iv[0] = 1'b1;
        id[0] = 4'h7;
        @(negedge clk);
        iv[0] = 1'b0;
        chk("coinc_count", 0, cnt[0], 1);
        chk("coinc_next_start", 0, tx[0], 0);
        wait_idle();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k] = $urandom_range(0, ((c / 500) % 2 != 0) ? 1 : 12) == 0;
                id[k] = 4'($urandom);
            end
            @(negedge clk);
        end
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
